// File: rtl/mm_pkg.sv
// Shared constants for the matrix multiply controller: address map, CTRL bits, FSM states.
// Pure declarations; no logic, no latency, no flow control.
package mm_pkg;

   localparam int BITS_DEF  = 8;
   localparam int SIZE_DEF  = 4;
   localparam int OUT_W_DEF = 2 * BITS_DEF + $clog2(SIZE_DEF);

   localparam logic [4:0] ADDR_A_BASE = 5'h00;
   localparam logic [4:0] ADDR_B_BASE = 5'h04;
   localparam logic [4:0] ADDR_CTRL   = 5'h08;
   localparam logic [4:0] ADDR_STATUS = 5'h09;
   localparam logic [4:0] ADDR_C_BASE = 5'h10;

   localparam int CTRL_START    = 0;
   localparam int CTRL_CLR_DONE = 1;
   localparam int CTRL_IRQ_EN   = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/dot4_pipe.sv
// Unsigned dot product of two packed SIZE-lane vectors; purely combinational.
// Zero latency (the parent registers operands and result); no flow control.
module dot4_pipe #(
   parameter int BITS  = 8,
   parameter int SIZE  = 4,
   parameter int OUT_W = 18
) (
   input  logic [BITS*SIZE-1:0] op_a,
   input  logic [BITS*SIZE-1:0] op_b,
   output logic [OUT_W-1:0]     dot
);

   always_comb begin
      dot = '0;
      for (int k = 0; k < SIZE; k++) begin
         dot = dot + OUT_W'(op_a[k*BITS +: BITS]) * OUT_W'(op_b[k*BITS +: BITS]);
      end
   end

endmodule

// File: rtl/matrix_mult_ctrl.sv
// Avalon-MM slave computing C = A x B (4x4) over one shared dot-product lane; 17 cycles START to done.
// 1-cycle registered read latency; no waitrequest, A/B/START writes are dropped while busy.
module matrix_mult_ctrl
   import mm_pkg::*;
#(
   parameter int BITS = BITS_DEF,
   parameter int SIZE = SIZE_DEF
) (
   input  logic        _CLK,
   input  logic        _RST_N,
   input  logic        _CS,
   input  logic        _WRITE_DATA,
   input  logic        _READ_DATA,
   input  logic [4:0]  _ADDR,
   input  logic [31:0] _DATA_IN,
   output logic [31:0] DATA_OUT_,
   output logic        IRQ_
);

   localparam int OUT_W = 2 * BITS + $clog2(SIZE);
   localparam int W     = BITS * SIZE;
   localparam int N     = SIZE * SIZE;

   state_t            state_q, state_d;
   logic [3:0]        idx_q, idx_d;
   logic [3:0]        widx_q, widx_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic              irq_en_q, irq_en_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [W-1:0]      op_a_q, op_a_d;
   logic [W-1:0]      op_b_q, op_b_d;
   logic [W-1:0]      a_q [SIZE];
   logic [W-1:0]      a_d [SIZE];
   logic [W-1:0]      b_q [SIZE];
   logic [W-1:0]      b_d [SIZE];
   logic [OUT_W-1:0]  c_q [N];
   logic [OUT_W-1:0]  c_d [N];
   logic [OUT_W-1:0]  dot;

   logic bus_wr, bus_rd, busy, start;

   dot4_pipe #(
      .BITS  (BITS),
      .SIZE  (SIZE),
      .OUT_W (OUT_W)
   ) u_dot (
      .op_a (op_a_q),
      .op_b (op_b_q),
      .dot  (dot)
   );

   assign bus_wr = _CS & _WRITE_DATA;
   assign bus_rd = _CS & _READ_DATA & ~_WRITE_DATA;
   assign busy   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign start  = bus_wr && (_ADDR == ADDR_CTRL) && _DATA_IN[CTRL_START] && !busy;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      widx_d   = widx_q;
      valid_d  = valid_q;
      done_d   = done_q;
      irq_en_d = irq_en_q;
      rdata_d  = rdata_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      a_d      = a_q;
      b_d      = b_q;
      c_d      = c_q;

      if (bus_wr && !busy && (_ADDR[4:2] == ADDR_A_BASE[4:2])) a_d[_ADDR[1:0]] = _DATA_IN;
      if (bus_wr && !busy && (_ADDR[4:2] == ADDR_B_BASE[4:2])) b_d[_ADDR[1:0]] = _DATA_IN;

      if (bus_wr && (_ADDR == ADDR_CTRL)) begin
         irq_en_d = _DATA_IN[CTRL_IRQ_EN];
         if (_DATA_IN[CTRL_CLR_DONE]) done_d = 1'b0;
      end

      // Result of the operands loaded on the previous edge lands here.
      if (valid_q) c_d[widx_q] = dot;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               idx_d   = '0;
               done_d  = 1'b0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            op_a_d = a_q[idx_q[3:2]];
            for (int k = 0; k < SIZE; k++) begin
               op_b_d[k*BITS +: BITS] = b_q[k][idx_q[1:0]*BITS +: BITS];
            end
            valid_d = 1'b1;
            widx_d  = idx_q;
            idx_d   = idx_q + 4'd1;
            if (idx_q == 4'd15) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (bus_rd) begin
         if (_ADDR[4]) begin
            rdata_d = 32'(c_q[_ADDR[3:0]]);
         end else if (_ADDR[4:2] == ADDR_A_BASE[4:2]) begin
            rdata_d = a_q[_ADDR[1:0]];
         end else if (_ADDR[4:2] == ADDR_B_BASE[4:2]) begin
            rdata_d = b_q[_ADDR[1:0]];
         end else if (_ADDR == ADDR_CTRL) begin
            rdata_d = {29'b0, irq_en_q, 2'b0};
         end else if (_ADDR == ADDR_STATUS) begin
            rdata_d = {30'b0, done_q, busy};
         end else begin
            rdata_d = '0;
         end
      end
   end

   always_ff @(posedge _CLK or negedge _RST_N) begin
      if (!_RST_N) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         widx_q   <= '0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
         irq_en_q <= 1'b0;
         rdata_q  <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         for (int i = 0; i < SIZE; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
         end
         for (int i = 0; i < N; i++) c_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         widx_q   <= widx_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
         irq_en_q <= irq_en_d;
         rdata_q  <= rdata_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         a_q      <= a_d;
         b_q      <= b_d;
         c_q      <= c_d;
      end
   end

   assign DATA_OUT_ = rdata_q;
   assign IRQ_      = done_q & irq_en_q;

endmodule

// File: tb/tb_matrix_mult_ctrl.sv
// Directed bench for matrix_mult_ctrl: identity, max values, timing/IRQ, busy protection,
// mid-run reset and bus corner cases, all against hand-computed values.
module tb_matrix_mult_ctrl;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        cs    = 1'b0;
   logic        wr    = 1'b0;
   logic        rd    = 1'b0;
   logic [4:0]  addr  = '0;
   logic [31:0] din   = '0;
   logic [31:0] dout;
   logic        irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   matrix_mult_ctrl dut (
      ._CLK        (clk),
      ._RST_N      (rst_n),
      ._CS         (cs),
      ._WRITE_DATA (wr),
      ._READ_DATA  (rd),
      ._ADDR       (addr),
      ._DATA_IN    (din),
      .DATA_OUT_   (dout),
      .IRQ_        (irq)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
      cs = 1'b1; wr = 1'b1; addr = a; din = d;
      @(posedge clk); #1;
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
      cs = 1'b1; rd = 1'b1; addr = a;
      @(posedge clk); #1;
      cs = 1'b0; rd = 1'b0;
      check_eq(tag, dout, exp);
   endtask

   task automatic wr_rows(input logic [4:0] base, input logic [31:0] r0, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] r3);
      bus_wr(base,        r0);
      bus_wr(base + 5'd1, r1);
      bus_wr(base + 5'd2, r2);
      bus_wr(base + 5'd3, r3);
   endtask

   task automatic load_identity_case();
      wr_rows(5'h00, 32'h0000_0001, 32'h0000_0100, 32'h0001_0000, 32'h0100_0000);
      wr_rows(5'h04, 32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D);
   endtask

   initial begin
      // reset
      #2 rst_n = 1'b0;
      tick(3);
      check_eq("rst_dout", dout, 32'h0);
      check_eq("rst_irq", {31'b0, irq}, 32'h0);
      rst_n = 1'b1;
      tick(1);
      rd_chk("rst_status", 5'h09, 32'h0);
      rd_chk("rst_ctrl", 5'h08, 32'h0);
      rd_chk("rst_c0", 5'h10, 32'h0);

      // identity: C = B, so C[i][j] = 4i+j+1
      load_identity_case();
      bus_wr(5'h08, 32'h1);
      tick(17);
      rd_chk("id_status", 5'h09, 32'h2);
      check_eq("id_irq_off", {31'b0, irq}, 32'h0);
      for (int i = 0; i < 16; i++) rd_chk($sformatf("id_c%0d", i), 5'h10 + 5'(i), 32'(i + 1));

      // all-ones operands: 4*255*255
      wr_rows(5'h00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wr_rows(5'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      bus_wr(5'h08, 32'h1);
      tick(17);
      for (int i = 0; i < 16; i++) rd_chk($sformatf("max_c%0d", i), 5'h10 + 5'(i), 32'h0003_F804);

      // timing and IRQ
      bus_wr(5'h08, 32'h4);
      rd_chk("irqen_ctrl", 5'h08, 32'h4);
      bus_wr(5'h08, 32'h5);                  // E0
      rd_chk("t_busy_e1", 5'h09, 32'h1);     // E1
      tick(15);                              // E16
      check_eq("t_irq_e16", {31'b0, irq}, 32'h0);
      rd_chk("t_status_e17", 5'h09, 32'h1);  // E17 samples DRAIN
      check_eq("t_irq_e17", {31'b0, irq}, 32'h1);
      rd_chk("t_status_done", 5'h09, 32'h2);
      bus_wr(5'h08, 32'h6);
      rd_chk("clr_status", 5'h09, 32'h0);
      check_eq("clr_irq", {31'b0, irq}, 32'h0);

      // busy protection
      load_identity_case();
      bus_wr(5'h08, 32'h5);                  // E0
      bus_wr(5'h00, 32'h0505_0505);          // E1, dropped
      bus_wr(5'h08, 32'h5);                  // E2, dropped START
      rd_chk("bz_ctrl", 5'h08, 32'h4);       // E3
      rd_chk("bz_status", 5'h09, 32'h1);     // E4
      tick(12);                              // E16
      check_eq("bz_irq_e16", {31'b0, irq}, 32'h0);
      tick(1);                               // E17
      check_eq("bz_irq_e17", {31'b0, irq}, 32'h1);
      rd_chk("bz_a0", 5'h00, 32'h0000_0001);
      for (int i = 0; i < 16; i++) rd_chk($sformatf("bz_c%0d", i), 5'h10 + 5'(i), 32'(i + 1));
      bus_wr(5'h08, 32'h6);

      // reset mid-run
      bus_wr(5'h08, 32'h5);                  // E0
      tick(8);                               // E8
      rst_n = 1'b0;
      #1;
      check_eq("mr_dout", dout, 32'h0);
      check_eq("mr_irq", {31'b0, irq}, 32'h0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      rd_chk("mr_status", 5'h09, 32'h0);
      rd_chk("mr_ctrl", 5'h08, 32'h0);
      for (int i = 0; i < 16; i++) rd_chk($sformatf("mr_c%0d", i), 5'h10 + 5'(i), 32'h0);

      // A all 2s: C[i][j] = 2 * sum_k (4k+j+1) = 56 + 8j
      wr_rows(5'h00, 32'h0202_0202, 32'h0202_0202, 32'h0202_0202, 32'h0202_0202);
      wr_rows(5'h04, 32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09, 32'h100F_0E0D);
      bus_wr(5'h08, 32'h1);
      tick(17);
      rd_chk("re_status", 5'h09, 32'h2);
      for (int i = 0; i < 16; i++) rd_chk($sformatf("re_c%0d", i), 5'h10 + 5'(i), 32'(56 + 8 * (i % 4)));

      // bus corners
      rd_chk("unmapped", 5'h0A, 32'h0);
      rd_chk("pre_rw", 5'h09, 32'h2);
      cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = 5'h00; din = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      cs = 1'b0; wr = 1'b0; rd = 1'b0;
      check_eq("rw_hold", dout, 32'h2);
      rd_chk("rw_a0", 5'h00, 32'hDEAD_BEEF);
      bus_wr(5'h10, 32'h0000_1234);
      rd_chk("c_ro", 5'h10, 32'd56);
      tick(2);
      check_eq("dout_hold", dout, 32'd56);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_mult_ctrl.md
Name: matrix_mult_ctrl

Overview:
- Avalon-MM slave that computes a full SIZE×SIZE unsigned matrix product C = A×B with a single shared dot-product datapath.
- Software writes the rows of A and B, then writes START. An FSM streams one (row of A, column of B) pair per cycle into a one-stage pipelined dot-product unit and stores the results in a 16-entry C register file.
- Sits between the HPS/Nios bus and the dot-product datapath. It owns sequencing, operand selection, result storage and the completion interrupt.

Parameters:
- BITS, 8, element width in bits (unsigned). BITS*SIZE must equal 32.
- SIZE, 4, matrix dimension. Fixed at 4 by the address map.
- OUT_W, 18, result width = 2*BITS + log2(SIZE). Derived; do not override.

Ports:
- _CLK  input  1  clock
- _RST_N  input  1  asynchronous active-low reset
- _CS  input  1  chip select
- _WRITE_DATA  input  1  write strobe, qualified by _CS
- _READ_DATA  input  1  read strobe, qualified by _CS
- _ADDR  input  5  word address
- _DATA_IN  input  32  write data
- DATA_OUT_  output  32  registered read data
- IRQ_  output  1  level interrupt = done_flag & irq_en

Behaviour:
- Reset (async, _RST_N=0):
  - A, B, C files = 0; FSM = IDLE; idx = 0.
  - done_flag = 0, irq_en = 0, DATA_OUT_ = 0, IRQ_ = 0, pipeline valid = 0.
- Address map:
  - 0x00-0x03: A row i. Byte k = A[i][k], byte 0 in bits [7:0].
  - 0x04-0x07: B row i. Same packing.
  - 0x08 CTRL:
    - write: bit0 START (self-clearing), bit1 CLR_DONE, bit2 irq_en (stored).
    - read: {29'b0, irq_en, 2'b0}.
  - 0x09 STATUS, read-only: {30'b0, done_flag, busy}.
  - 0x10-0x1F: C[i][j] at 0x10 + 4i + j, read-only, zero-extended from OUT_W bits.
  - All other addresses read 0; writes to them are ignored.
- Bus rules:
  - Writes take effect at the clock edge with _CS & _WRITE_DATA.
  - Reads: DATA_OUT_ updated at the edge with _CS & _READ_DATA & !_WRITE_DATA (1-cycle read latency). Otherwise DATA_OUT_ holds.
  - Simultaneous read and write: the write wins and DATA_OUT_ holds.
- FSM states: IDLE, RUN, DRAIN, DONE. busy = (RUN or DRAIN).
  - IDLE/DONE + START write (edge E0):
    - idx <= 0, done_flag <= 0, go to RUN.
    - If CLR_DONE and START are set in the same write, START wins.
  - RUN, edges E1..E16 (idx 0..15):
    - Operand regs <= A row (idx>>2) and B column (idx&3). The column is gathered byte-wise from the 4 B rows.
    - valid_q <= 1; idx++.
    - At idx==15 go to DRAIN.
  - Pipeline: whenever valid_q is 1 at an edge, C[widx] <= dot(op_a, op_b), with widx = idx delayed one cycle. C writes therefore occur at E2..E17.
  - DRAIN (E17): final C write, valid_q <= 0, done_flag <= 1, go to DONE.
  - DONE: holds until START. CLR_DONE clears done_flag and stays in DONE.
  - Total: 17 cycles from the START edge to done_flag = 1.
- While busy:
  - Writes to A/B/START are ignored.
  - CTRL irq_en and CLR_DONE writes are honoured.
  - C reads return the currently stored value (may be stale or partial).
- Arithmetic:
  - Unsigned 8×8 products, sum of 4 products, no saturation.
  - Max value 4·255·255 = 260100 = 0x3F804, which fits in 18 bits.
- Reset mid-operation aborts immediately to reset state. No partial C is retained.

Decomposition:
- Package mm_pkg:
  - address constants: ADDR_A_BASE, ADDR_B_BASE, ADDR_CTRL, ADDR_STATUS, ADDR_C_BASE
  - CTRL bit indices
  - FSM state encoding
  - BITS/SIZE/OUT_W defaults
- One sub-module dot4_pipe: combinational 4-lane multiply-accumulate over two packed 32-bit operands, producing OUT_W bits. It is registered in the parent via op regs and the C write.
- The FSM, register files and bus decode stay in matrix_mult_ctrl.

Test Plan:
- Identity: A = I (rows 0x00000001, 0x00000100, 0x00010000, 0x01000000), B rows 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D, START -> C[i][j] = B[i][j] (e.g. 0x10 reads 1, 0x1F reads 16).
- Max values: all A and B rows 0xFFFFFFFF, START -> every C reads 0x0003F804, with no overflow.
- Timing and IRQ: write CTRL irq_en=1 then START at edge E0 -> busy=1 from E0, STATUS reads 0x2 and IRQ_=1 exactly after E17. Write CLR_DONE -> STATUS 0x0 and IRQ_=0.
- Busy protection: write A row0 = 0x05050505 and a second START during RUN -> ignored, C matches the pre-start A, done at E17 unchanged. Read 0x08/0x09 during RUN -> busy bit 1.
- Reset mid-run: assert _RST_N low at E8 -> STATUS 0, all C read 0, IRQ_=0, and a subsequent START with reloaded data completes normally.
- Bus corner cases: read an unmapped address 0x0A -> 0. Simultaneous read and write to 0x00 -> A updated, DATA_OUT_ unchanged. Write to 0x10 -> C unchanged.
